// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary pointer conversion and parameter range checks.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

// Elaboration-time guard: emits a named generate block that errors out when cond is false.
`define FIFO_CHECK(label, cond) \
  if (!(cond)) begin : label \
    $error("async_fifo_prog: illegal parameter, range check failed"); \
  end

package fifo_pkg;

  // Conversions work at a fixed maximum width; callers zero-extend and truncate with casts.
  localparam int unsigned PTR_W_MAX = 32;

  typedef logic [PTR_W_MAX-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin = gray;
    for (int i = int'(PTR_W_MAX) - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

`endif

// File: rtl/async_fifo_prog_if.sv
// Producer/consumer bus of the dual-clock FIFO; write-side signals belong to wr_clk, read-side to rd_clk.
interface async_fifo_prog_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_count;
  logic                  overflow;

  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  rd_valid;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   rd_count;
  logic                  underflow;

  modport master (
    output wr_en, din, rd_en,
    input  full, almost_full, wr_count, overflow,
    input  dout, rd_valid, empty, almost_empty, rd_count, underflow
  );

  modport slave (
    input  wr_en, din, rd_en,
    output full, almost_full, wr_count, overflow,
    output dout, rd_valid, empty, almost_empty, rd_count, underflow
  );

endinterface

// File: rtl/cdc_gray_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into the clk domain.
module cdc_gray_sync #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_prog.sv
// Dual-clock FIFO with Gray pointer CDC, programmable almost flags, fill counts, sticky error flags
// and optional first-word-fall-through read.
module async_fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AF_THRESH   = 12,
  parameter int unsigned AE_THRESH   = 2,
  parameter int unsigned FWFT        = 0
) (
  input  logic                wr_clk,
  input  logic                rd_clk,
  input  logic                reset_n,
  async_fifo_prog_if.slave    bus
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  `FIFO_CHECK(g_chk_aw,   ADDR_WIDTH >= 2 && ADDR_WIDTH <= PTR_W_MAX - 2)
  `FIFO_CHECK(g_chk_dw,   DATA_WIDTH >= 1)
  `FIFO_CHECK(g_chk_sync, SYNC_STAGES >= 2)
  `FIFO_CHECK(g_chk_af,   AF_THRESH >= 1 && AF_THRESH <= DEPTH)
  `FIFO_CHECK(g_chk_ae,   AE_THRESH <= DEPTH - 1)
  `FIFO_CHECK(g_chk_fwft, FWFT <= 1)

  // Per-domain reset: asserts asynchronously, releases on the domain's own clock.
  logic [1:0] wr_rst_q, rd_rst_q;
  logic       wr_rst_n, rd_rst_n;

  always_ff @(posedge wr_clk or negedge reset_n) begin
    if (!reset_n) wr_rst_q <= '0;
    else          wr_rst_q <= {wr_rst_q[0], 1'b1};
  end

  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) rd_rst_q <= '0;
    else          rd_rst_q <= {rd_rst_q[0], 1'b1};
  end

  assign wr_rst_n = wr_rst_q[1];
  assign rd_rst_n = rd_rst_q[1];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write domain
  logic [PTR_W-1:0]      wr_bin, wr_gray, rd_gray_sync, wr_count_c, wr_bin_nxt;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  full_c, wr_accept, overflow_q;

  assign wr_addr     = wr_bin[ADDR_WIDTH-1:0];
  assign wr_bin_nxt  = wr_bin + PTR_W'(1);
  assign wr_count_c  = wr_bin - PTR_W'(gray2bin(ptr_t'(rd_gray_sync)));
  assign full_c      = (wr_count_c == PTR_W'(DEPTH));
  assign wr_accept   = bus.wr_en && !full_c;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_bin     <= '0;
      wr_gray    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_bin  <= wr_bin_nxt;
        wr_gray <= PTR_W'(bin2gray(ptr_t'(wr_bin_nxt)));
      end
      if (bus.wr_en && full_c) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_accept) mem[wr_addr] <= bus.din;
  end

  assign bus.full        = full_c;
  assign bus.almost_full = (32'(wr_count_c) >= AF_THRESH);
  assign bus.wr_count    = wr_count_c;
  assign bus.overflow    = overflow_q;

  // Read domain
  logic [PTR_W-1:0]      rd_bin, rd_gray, wr_gray_sync, rd_count_c, rd_bin_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  empty_c, rd_accept, underflow_q;

  assign rd_addr    = rd_bin[ADDR_WIDTH-1:0];
  assign rd_bin_nxt = rd_bin + PTR_W'(1);
  assign rd_count_c = PTR_W'(gray2bin(ptr_t'(wr_gray_sync))) - rd_bin;
  assign empty_c    = (rd_count_c == '0);
  assign rd_accept  = bus.rd_en && !empty_c;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_bin      <= '0;
      rd_gray     <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (rd_accept) begin
        rd_bin  <= rd_bin_nxt;
        rd_gray <= PTR_W'(bin2gray(ptr_t'(rd_bin_nxt)));
      end
      if (bus.rd_en && empty_c) underflow_q <= 1'b1;
    end
  end

  if (FWFT == 0) begin : g_std_read
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  rd_valid_q;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
        dout_q     <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_accept;
        if (rd_accept) dout_q <= mem[rd_addr];
      end
    end

    assign bus.dout     = dout_q;
    assign bus.rd_valid = rd_valid_q;
  end else begin : g_fwft_read
    assign bus.dout     = mem[rd_addr];
    assign bus.rd_valid = !empty_c;
  end

  assign bus.empty        = empty_c;
  assign bus.almost_empty = (32'(rd_count_c) <= AE_THRESH);
  assign bus.rd_count     = rd_count_c;
  assign bus.underflow    = underflow_q;

  // Only Gray pointers cross between the clock domains.
  cdc_gray_sync #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_sync_rd2wr (
    .clk     (wr_clk),
    .reset_n (wr_rst_n),
    .d       (rd_gray),
    .q       (rd_gray_sync)
  );

  cdc_gray_sync #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_sync_wr2rd (
    .clk     (rd_clk),
    .reset_n (rd_rst_n),
    .d       (wr_gray),
    .q       (wr_gray_sync)
  );

endmodule

// File: tb/tb_async_fifo_prog.sv
// Directed bench for async_fifo_prog: a standard-read and a FWFT instance on shared clocks and reset.
module tb_async_fifo_prog;

  logic wr_clk  = 1'b0;
  logic rd_clk  = 1'b0;
  logic reset_n = 1'b0;
  int   wr_half = 10;
  int   rd_half = 27;

  int n_checks = 0;
  int n_fail   = 0;

  always #(wr_half) wr_clk = ~wr_clk;
  always #(rd_half) rd_clk = ~rd_clk;

  async_fifo_prog_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus0 ();
  async_fifo_prog_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus1 ();

  async_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .SYNC_STAGES(2),
                    .AF_THRESH(12), .AE_THRESH(2), .FWFT(0)) u_dut_std (
    .wr_clk (wr_clk), .rd_clk (rd_clk), .reset_n (reset_n), .bus (bus0.slave)
  );

  async_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .SYNC_STAGES(2),
                    .AF_THRESH(12), .AE_THRESH(2), .FWFT(1)) u_dut_fwft (
    .wr_clk (wr_clk), .rd_clk (rd_clk), .reset_n (reset_n), .bus (bus1.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.din = '0;
    bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.din = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge rd_clk);
    #3 reset_n = 1'b1;
    repeat (4) @(posedge wr_clk);
    repeat (4) @(posedge rd_clk);
  endtask

  task automatic read_pulse0();
    @(negedge rd_clk) bus0.rd_en = 1'b1;
    @(negedge rd_clk) bus0.rd_en = 1'b0;
  endtask

  // Random traffic with enables gated by the flags; data order checked against a queue.
  task automatic run_stream(input int nwords);
    logic [7:0] q[$];
    int sent = 0;
    int rcvd = 0;
    fork
      begin
        int cyc = 0;
        while (sent < nwords && cyc < 40000) begin
          @(negedge wr_clk);
          cyc++;
          if (!bus0.full && ($urandom_range(0, 9) < 6)) begin
            logic [7:0] w;
            w = 8'($urandom);
            bus0.wr_en = 1'b1;
            bus0.din   = w;
            q.push_back(w);
            sent++;
          end else begin
            bus0.wr_en = 1'b0;
          end
        end
        @(negedge wr_clk) bus0.wr_en = 1'b0;
      end
      begin
        int cyc = 0;
        while (rcvd < nwords && cyc < 40000) begin
          @(negedge rd_clk);
          cyc++;
          if (bus0.rd_valid) begin
            if (q.size() == 0) check_eq("stream_extra_word", 32'(q.size()), 1);
            else               check_eq("stream_data", 32'(bus0.dout), 32'(q.pop_front()));
            rcvd++;
          end
          bus0.rd_en = !bus0.empty && ($urandom_range(0, 9) < 5);
        end
        @(negedge rd_clk) bus0.rd_en = 1'b0;
      end
    join
    check_eq("stream_received", 32'(rcvd), 32'(nwords));
    check_eq("stream_leftover", 32'(q.size()), 0);
    check_eq("stream_wraps_ge50", 32'(sent / 32 >= 50), 1);
    check_eq("stream_overflow", 32'(bus0.overflow), 0);
    check_eq("stream_underflow", 32'(bus0.underflow), 0);
  endtask

  initial begin
    bit seen;

    // Reset state
    bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.din = '0;
    bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.din = '0;
    #30;
    check_eq("rst_empty",        32'(bus0.empty), 1);
    check_eq("rst_full",         32'(bus0.full), 0);
    check_eq("rst_almost_empty", 32'(bus0.almost_empty), 1);
    check_eq("rst_almost_full",  32'(bus0.almost_full), 0);
    check_eq("rst_wr_count",     32'(bus0.wr_count), 0);
    check_eq("rst_rd_count",     32'(bus0.rd_count), 0);
    check_eq("rst_dout",         32'(bus0.dout), 0);
    check_eq("rst_rd_valid",     32'(bus0.rd_valid), 0);
    check_eq("rst_overflow",     32'(bus0.overflow), 0);
    check_eq("rst_underflow",    32'(bus0.underflow), 0);
    #3 reset_n = 1'b1;
    repeat (4) @(posedge wr_clk);
    repeat (4) @(posedge rd_clk);

    // Fill to full with the reader idle, then one dropped write
    for (int k = 1; k <= 16; k++) begin
      @(negedge wr_clk);
      bus0.wr_en = 1'b1;
      bus0.din   = 8'(k - 1);
      @(negedge wr_clk);
      bus0.wr_en = 1'b0;
      check_eq("fill_wr_count",    32'(bus0.wr_count), 32'(k));
      check_eq("fill_almost_full", 32'(bus0.almost_full), 32'(k >= 12));
      check_eq("fill_full",        32'(bus0.full), 32'(k == 16));
    end
    check_eq("fill_overflow_pre", 32'(bus0.overflow), 0);
    @(negedge wr_clk);
    bus0.wr_en = 1'b1;
    bus0.din   = 8'hFF;
    @(negedge wr_clk);
    bus0.wr_en = 1'b0;
    check_eq("ovf_flag",     32'(bus0.overflow), 1);
    check_eq("ovf_wr_count", 32'(bus0.wr_count), 16);
    check_eq("ovf_full",     32'(bus0.full), 1);

    // Drain all sixteen in order, then one read past empty
    repeat (4) @(negedge rd_clk);
    check_eq("drain_rd_count_start", 32'(bus0.rd_count), 16);
    for (int i = 0; i < 16; i++) begin
      read_pulse0();
      check_eq("drain_dout",         32'(bus0.dout), 32'(i));
      check_eq("drain_rd_valid",     32'(bus0.rd_valid), 1);
      check_eq("drain_rd_count",     32'(bus0.rd_count), 32'(15 - i));
      check_eq("drain_almost_empty", 32'(bus0.almost_empty), 32'(15 - i <= 2));
    end
    check_eq("drain_empty", 32'(bus0.empty), 1);
    read_pulse0();
    check_eq("udf_flag",     32'(bus0.underflow), 1);
    check_eq("udf_dout",     32'(bus0.dout), 32'h0F);
    check_eq("udf_rd_valid", 32'(bus0.rd_valid), 0);
    check_eq("udf_overflow_sticky", 32'(bus0.overflow), 1);

    // First-word-fall-through: word visible without a read request
    @(negedge wr_clk);
    bus1.wr_en = 1'b1;
    bus1.din   = 8'hA5;
    @(posedge wr_clk);
    #1 bus1.wr_en = 1'b0;
    seen = 1'b0;
    for (int e = 0; e < 3 && !seen; e++) begin
      @(posedge rd_clk);
      #1 seen = !bus1.empty;
    end
    check_eq("fwft_visible_3_edges", 32'(seen), 1);
    check_eq("fwft_dout",     32'(bus1.dout), 32'hA5);
    check_eq("fwft_rd_valid", 32'(bus1.rd_valid), 1);
    check_eq("fwft_rd_count", 32'(bus1.rd_count), 1);
    @(negedge rd_clk) bus1.rd_en = 1'b1;
    @(posedge rd_clk);
    #1 bus1.rd_en = 1'b0;
    check_eq("fwft_pop_empty",     32'(bus1.empty), 1);
    check_eq("fwft_pop_rd_valid",  32'(bus1.rd_valid), 0);
    check_eq("fwft_pop_underflow", 32'(bus1.underflow), 0);

    // Random streaming, fast writer then fast reader
    do_reset();
    run_stream(2000);
    wr_half = 27;
    rd_half = 10;
    do_reset();
    run_stream(2000);
    wr_half = 10;
    rd_half = 27;

    // Reset mid-burst discards stored words
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge wr_clk);
      bus0.wr_en = 1'b1;
      bus0.din   = 8'(8'h10 + i);
    end
    @(negedge wr_clk) bus0.din = 8'h17;
    #3 reset_n = 1'b0;
    bus0.wr_en = 1'b0;
    #5;
    check_eq("midrst_empty",    32'(bus0.empty), 1);
    check_eq("midrst_wr_count", 32'(bus0.wr_count), 0);
    check_eq("midrst_rd_count", 32'(bus0.rd_count), 0);
    repeat (2) @(posedge rd_clk);
    #3 reset_n = 1'b1;
    repeat (4) @(posedge wr_clk);
    repeat (4) @(posedge rd_clk);
    check_eq("postrst_empty",    32'(bus0.empty), 1);
    check_eq("postrst_wr_count", 32'(bus0.wr_count), 0);
    check_eq("postrst_rd_count", 32'(bus0.rd_count), 0);
    @(negedge wr_clk);
    bus0.wr_en = 1'b1;
    bus0.din   = 8'h3C;
    @(negedge wr_clk) bus0.wr_en = 1'b0;
    seen = 1'b0;
    for (int e = 0; e < 6 && !seen; e++) begin
      @(negedge rd_clk);
      seen = !bus0.empty;
    end
    check_eq("postrst_visible", 32'(seen), 1);
    check_eq("postrst_rd_count_one", 32'(bus0.rd_count), 1);
    read_pulse0();
    check_eq("postrst_dout",     32'(bus0.dout), 32'h3C);
    check_eq("postrst_rd_valid", 32'(bus0.rd_valid), 1);
    check_eq("postrst_empty_after", 32'(bus0.empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
